// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampled, mid-bit sampling, with a valid/ack
// output handshake, a sticky overrun flag and a frame-error pulse.
`timescale 1ns/1ps
module uart_rx #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic       CLK_50,
   input  logic       RST_N,
   input  logic       RxD,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   output logic       rx_overrun,
   output logic       rx_frame_err,
   output logic       rx_busy
);

   localparam int DIV = (CLK_FREQ + BAUD * (OVERSAMPLE / 2)) / (BAUD * OVERSAMPLE);
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW  = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
   localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t          state;
   logic            rxd_meta;
   logic            rxd_sync;
   logic [1:0]      prime;
   logic            armed;
   logic [TW-1:0]   tick_cnt;
   logic [SW-1:0]   samp_cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      shift;
   logic            tick;

   assign tick = (tick_cnt == TICK_LAST);

   // The synchronizer resets to idle-high, so its output only reflects the
   // real line once both flops have been refilled; arming waits for that.
   always_ff @(posedge CLK_50 or negedge RST_N) begin
      if (!RST_N) begin
         rxd_meta <= 1'b1;
         rxd_sync <= 1'b1;
         prime    <= 2'b00;
         armed    <= 1'b0;
      end else begin
         rxd_meta <= RxD;
         rxd_sync <= rxd_meta;
         prime    <= {prime[0], 1'b1};
         if (prime[1] && rxd_sync)
            armed <= 1'b1;
      end
   end

   always_ff @(posedge CLK_50 or negedge RST_N) begin
      if (!RST_N) begin
         state        <= IDLE;
         tick_cnt     <= '0;
         samp_cnt     <= '0;
         bit_cnt      <= '0;
         shift        <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_overrun   <= 1'b0;
         rx_frame_err <= 1'b0;
         rx_busy      <= 1'b0;
      end else begin
         rx_frame_err <= 1'b0;
         tick_cnt     <= tick ? '0 : tick_cnt + TW'(1);
         if (rx_ack && rx_valid) begin
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (armed && !rxd_sync) begin
                  state    <= START;
                  rx_busy  <= 1'b1;
                  tick_cnt <= '0;
                  samp_cnt <= '0;
               end
            end
            START: begin
               if (tick) begin
                  if (samp_cnt == SAMP_MID) begin
                     samp_cnt <= '0;
                     bit_cnt  <= '0;
                     if (rxd_sync) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                     end else begin
                        state   <= DATA;
                     end
                  end else begin
                     samp_cnt <= samp_cnt + SW'(1);
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (samp_cnt == SAMP_LAST) begin
                     samp_cnt <= '0;
                     shift    <= {rxd_sync, shift[7:1]};
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7)
                        state <= STOP;
                  end else begin
                     samp_cnt <= samp_cnt + SW'(1);
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  if (samp_cnt == SAMP_LAST) begin
                     samp_cnt <= '0;
                     if (rxd_sync) begin
                        state    <= IDLE;
                        rx_busy  <= 1'b0;
                        rx_data  <= shift;
                        rx_valid <= 1'b1;
                        // A same-cycle ack consumes the old byte, so no loss.
                        if (rx_valid && !rx_ack)
                           rx_overrun <= 1'b1;
                     end else begin
                        rx_frame_err <= 1'b1;
                        state        <= BREAK;
                     end
                  end else begin
                     samp_cnt <= samp_cnt + SW'(1);
                  end
               end
            end
            BREAK: begin
               if (rxd_sync) begin
                  state   <= IDLE;
                  rx_busy <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               rx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
